cpu_run_controller: RTL and testbench

// Sequences one run of the stack CPU against its data RAM: host preload -> CPU reset -> run -> halt/timeout -> result check.

---
 rtl/cpu_ctrl_pkg.sv | 27 ++
 rtl/cpu_run_controller_halt_detector.sv | 36 +++
 rtl/cpu_run_controller.sv | 158 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the stack CPU run controller.
package cpu_ctrl_pkg;

  // Run sequencing states; RESET_CPU..CHECK_DATA are the busy states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_CPU  = 3'd1,
    RUN        = 3'd2,
    CHECK_ADDR = 3'd3,
    CHECK_DATA = 3'd4,
    DONE       = 3'd5
  } run_state_e;

  // Opcode the CPU sits on once its program has finished.
  localparam logic [3:0] OP_HALT = 4'hF;

  // Defaults for where the program leaves its verdict and what it means.
  localparam int RESULT_ADDR_DEFAULT = 135;
  localparam int PASS_VALUE_DEFAULT  = 2;
  localparam int HALT_CYCLES_DEFAULT = 4;

  // The host owns the RAM ports whenever the CPU is parked and idle.
  function automatic logic isHostOwned(input run_state_e state);
    return (state == IDLE) || (state == DONE);
  endfunction

endpackage

// File: rtl/cpu_run_controller_halt_detector.sv
// Counts consecutive halt opcodes; reports halted once the run of them is long enough.
module halt_detector
  import cpu_ctrl_pkg::*;
#(
  parameter int HALT_CYCLES = HALT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] opcode,
  output logic       halted
);

  localparam int CW = $clog2(HALT_CYCLES + 1);
  localparam logic [CW-1:0] HALT_TARGET = CW'(HALT_CYCLES);

  logic [CW-1:0] haltCount;

  // Consecutive-halt counter: saturates at the target, any other opcode restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      haltCount <= '0;
    end else if (clear) begin
      haltCount <= '0;
    end else if (opcode == OP_HALT) begin
      if (haltCount != HALT_TARGET) begin
        haltCount <= haltCount + 1'b1;
      end
    end else begin
      haltCount <= '0;
    end
  end

  assign halted = (haltCount == HALT_TARGET);

endmodule

// File: rtl/cpu_run_controller.sv
// Sequences one stack CPU run: host preload, CPU reset, run, halt/timeout, result check.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int TIMER_BITS  = 20,
  parameter int RESULT_ADDR = RESULT_ADDR_DEFAULT,
  parameter int PASS_VALUE  = PASS_VALUE_DEFAULT,
  parameter int HALT_CYCLES = HALT_CYCLES_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TIMER_BITS-1:0] timeout_limit,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_BITS-1:0]  load_addr,
  input  logic [DATA_BITS-1:0]  load_data,
  output logic                  cpu_reset,
  input  logic [11:0]           cpu_instruction,
  input  logic                  cpu_write_en,
  input  logic [ADDR_BITS-1:0]  cpu_write_addr,
  input  logic [DATA_BITS-1:0]  cpu_write_val,
  input  logic [ADDR_BITS-1:0]  cpu_read_addr,
  output logic                  mem_write_en,
  output logic [ADDR_BITS-1:0]  mem_write_addr,
  output logic [DATA_BITS-1:0]  mem_write_val,
  output logic [ADDR_BITS-1:0]  mem_read_addr,
  input  logic [DATA_BITS-1:0]  mem_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic [TIMER_BITS-1:0] cycle_count
);

  localparam logic [ADDR_BITS-1:0] RESULT_ADDR_W = ADDR_BITS'(RESULT_ADDR);
  localparam logic [DATA_BITS-1:0] PASS_VALUE_W  = DATA_BITS'(PASS_VALUE);

  run_state_e            stateReg;
  run_state_e            stateNext;
  logic [TIMER_BITS-1:0] limitReg;
  logic [TIMER_BITS-1:0] cycleReg;
  logic                  passReg;
  logic                  timedOutReg;
  logic                  halted;
  logic                  hostOwned;
  logic                  timeoutHit;
  logic [TIMER_BITS-1:0] cycleInc;
  logic                  unusedOperandBits;

  // Only the opcode nibble matters here; the operand byte is deliberately ignored.
  assign unusedOperandBits = ^cpu_instruction[7:0];

  assign hostOwned  = isHostOwned(stateReg);
  assign timeoutHit = (cycleReg == limitReg);
  assign cycleInc   = (&cycleReg) ? cycleReg : cycleReg + 1'b1;

  // Halt counter only runs in RUN so every run starts from a clean count.
  halt_detector #(
    .HALT_CYCLES(HALT_CYCLES)
  ) haltDetector (
    .clock  (clock),
    .reset  (reset),
    .clear  (stateReg != RUN),
    .opcode (cpu_instruction[11:8]),
    .halted (halted)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic; halt and timeout both end RUN through the result check.
  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE, DONE: if (start) stateNext = RESET_CPU;
      RESET_CPU:  stateNext = RUN;
      RUN:        if (halted || timeoutHit) stateNext = CHECK_ADDR;
      CHECK_ADDR: stateNext = CHECK_DATA;
      CHECK_DATA: stateNext = DONE;
      default:    stateNext = IDLE;
    endcase
  end

  // Run bookkeeping: limit latch, cycle timer and the two verdict flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      limitReg    <= '0;
      cycleReg    <= '0;
      passReg     <= 1'b0;
      timedOutReg <= 1'b0;
    end else begin
      if (hostOwned && start) begin
        limitReg    <= timeout_limit;
        cycleReg    <= '0;
        passReg     <= 1'b0;
        timedOutReg <= 1'b0;
      end else if (stateReg == RUN) begin
        cycleReg <= cycleInc;
        // A halt seen on the timeout clock still counts as a clean halt.
        if (halted) begin
          timedOutReg <= 1'b0;
        end else if (timeoutHit) begin
          timedOutReg <= 1'b1;
        end
      end else if (stateReg == CHECK_DATA) begin
        passReg <= (mem_read_data == PASS_VALUE_W);
      end
    end
  end

  // RAM port ownership: host while parked, CPU in RUN, read-only result fetch in CHECK_*.
  always_comb begin
    load_ready     = 1'b0;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_write_val  = '0;
    mem_read_addr  = '0;
    unique case (stateReg)
      IDLE, DONE: begin
        load_ready     = 1'b1;
        mem_write_en   = load_valid;
        mem_write_addr = load_addr;
        mem_write_val  = load_data;
        mem_read_addr  = load_addr;
      end
      RUN: begin
        mem_write_en   = cpu_write_en;
        mem_write_addr = cpu_write_addr;
        mem_write_val  = cpu_write_val;
        mem_read_addr  = cpu_read_addr;
      end
      CHECK_ADDR, CHECK_DATA: begin
        mem_read_addr = RESULT_ADDR_W;
      end
      default: begin
        mem_read_addr = '0;
      end
    endcase
  end

  // Status outputs come straight from state so an async reset parks the CPU at once.
  assign cpu_reset   = (stateReg != RUN);
  assign busy        = !hostOwned;
  assign done        = (stateReg == DONE);
  assign pass        = passReg;
  assign timed_out   = timedOutReg;
  assign cycle_count = cycleReg;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: bench RAM, scripted CPU stand-in, run-level model.
module tb_cpu_run_controller;

  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 8;
  localparam int TIMER_BITS = 20;
  localparam int RES_ADDR   = 135;

  logic                  clock;
  logic                  reset;
  logic                  start;
  logic [TIMER_BITS-1:0] timeout_limit;
  logic                  load_valid;
  logic                  load_ready;
  logic [ADDR_BITS-1:0]  load_addr;
  logic [DATA_BITS-1:0]  load_data;
  logic                  cpu_reset;
  logic [11:0]           cpu_instruction;
  logic                  cpu_write_en;
  logic [ADDR_BITS-1:0]  cpu_write_addr;
  logic [DATA_BITS-1:0]  cpu_write_val;
  logic [ADDR_BITS-1:0]  cpu_read_addr;
  logic                  mem_write_en;
  logic [ADDR_BITS-1:0]  mem_write_addr;
  logic [DATA_BITS-1:0]  mem_write_val;
  logic [ADDR_BITS-1:0]  mem_read_addr;
  logic [DATA_BITS-1:0]  mem_read_data;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  timed_out;
  logic [TIMER_BITS-1:0] cycle_count;

  cpu_run_controller dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .timeout_limit   (timeout_limit),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .cpu_reset       (cpu_reset),
    .cpu_instruction (cpu_instruction),
    .cpu_write_en    (cpu_write_en),
    .cpu_write_addr  (cpu_write_addr),
    .cpu_write_val   (cpu_write_val),
    .cpu_read_addr   (cpu_read_addr),
    .mem_write_en    (mem_write_en),
    .mem_write_addr  (mem_write_addr),
    .mem_write_val   (mem_write_val),
    .mem_read_addr   (mem_read_addr),
    .mem_read_data   (mem_read_data),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timed_out       (timed_out),
    .cycle_count     (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data RAM with registered read, written only through the controller's mux.
  logic [7:0] ram [0:255];
  always @(posedge clock) begin
    if (mem_write_en) ram[mem_write_addr] <= mem_write_val;
    mem_read_data <= ram[mem_read_addr];
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] shadow [0:255];
  logic [3:0] opSeq [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Run-level model: find the first RUN clock preceded by four halt opcodes,
  // race it against the timeout clock (index == limit), halt winning ties.
  function automatic void predict(input int limit, input int wIdx, input logic [7:0] wVal,
                                  output int runClocks, output bit expTo, output bit expPass);
    int run;
    int haltIdx;
    int lastIdx;
    logic [7:0] result;
    run = 0;
    haltIdx = -1;
    for (int i = 0; i <= limit; i++) begin
      if (run >= 4) begin
        haltIdx = i;
        break;
      end
      run = (opSeq[i] == 4'hF) ? run + 1 : 0;
    end
    if (haltIdx >= 0) begin
      lastIdx = haltIdx;
      expTo = 1'b0;
    end else begin
      lastIdx = limit;
      expTo = 1'b1;
    end
    runClocks = lastIdx + 1;
    result = (wIdx >= 0 && wIdx <= lastIdx) ? wVal : shadow[RES_ADDR];
    shadow[RES_ADDR] = result;
    expPass = (result == 8'd2);
  endfunction

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    #1;
    check("preload_ready", load_ready, 1);
    check("idle_read_addr", mem_read_addr, addr);
    @(negedge clock);
    load_valid = 1'b0;
    shadow[addr] = data;
    check("preload_ram", ram[addr], data);
  endtask

  task automatic runOne(input string tag, input int limit, input int wIdx, input logic [7:0] wVal,
                        input bit coLoad, input bit hostPoke, input bit useTable,
                        input int tCount, input bit tPass, input bit tTo);
    int mCount;
    bit mTo;
    bit mPass;
    int expCount;
    bit expPass;
    bit expTo;
    int i;
    int cyc;
    predict(limit, wIdx, wVal, mCount, mTo, mPass);
    expCount = useTable ? tCount : mCount;
    expPass  = useTable ? tPass : mPass;
    expTo    = useTable ? tTo : mTo;

    start = 1'b1;
    timeout_limit = TIMER_BITS'(limit);
    if (coLoad) begin
      load_valid = 1'b1;
      load_addr  = 8'd140;
      load_data  = 8'h6d;
      shadow[140] = 8'h6d;
    end
    @(negedge clock);
    start = 1'b0;
    load_valid = 1'b0;
    check({tag, "_rst_cpu_busy"}, busy, 1);
    check({tag, "_rst_cpu_hold"}, cpu_reset, 1);
    check({tag, "_clr_done"}, done, 0);
    check({tag, "_clr_pass"}, pass, 0);
    check({tag, "_clr_to"}, timed_out, 0);
    check({tag, "_clr_count"}, cycle_count, 0);
    @(negedge clock);

    i = 0;
    cyc = 0;
    while (!done && cyc < limit + 40) begin
      if (!cpu_reset) begin
        if (i == 0) check({tag, "_run_load_ready"}, load_ready, 0);
        cpu_instruction = {(i < 1024) ? opSeq[i] : 4'h0, 8'($urandom)};
        cpu_write_en   = (i == wIdx);
        cpu_write_addr = 8'(RES_ADDR);
        cpu_write_val  = wVal;
        cpu_read_addr  = 8'($urandom);
        start      = hostPoke && (i == 1);
        load_valid = hostPoke && (i == 1);
        load_addr  = 8'd200;
        load_data  = ~shadow[200];
        i++;
      end else begin
        // CPU keeps trying to write during the result check; it must be ignored.
        start           = 1'b0;
        load_valid      = 1'b0;
        cpu_instruction = 12'h0;
        cpu_write_en    = 1'b1;
        cpu_write_addr  = 8'd201;
        cpu_write_val   = 8'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    cpu_write_en = 1'b0;
    start = 1'b0;
    load_valid = 1'b0;

    check({tag, "_done"}, done, 1);
    check({tag, "_pass"}, pass, expPass);
    check({tag, "_timed_out"}, timed_out, expTo);
    check({tag, "_cycle_count"}, cycle_count, expCount);
    check({tag, "_run_clocks"}, i, expCount);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_cpu_reset"}, cpu_reset, 1);
    check({tag, "_idle_load_ready"}, load_ready, 1);
    check({tag, "_ram_result"}, ram[RES_ADDR], shadow[RES_ADDR]);
    check({tag, "_ram_200"}, ram[200], shadow[200]);
    check({tag, "_ram_201"}, ram[201], shadow[201]);
    if (coLoad) check({tag, "_ram_140"}, ram[140], 8'h6d);
    $display("run %s limit=%0d count=%0d pass=%0b timed_out=%0b", tag, limit, cycle_count, pass, timed_out);
  endtask

  typedef struct {
    int limit;
    int haltStart;
    int wIdx;
    int wVal;
    bit coLoad;
    bit hostPoke;
    int expCount;
    bit expPass;
    bit expTo;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    vecs[0] = '{limit: 100,  haltStart: 6,  wIdx: 3,  wVal: 2, coLoad: 1, hostPoke: 0, expCount: 11,   expPass: 1, expTo: 0};
    vecs[1] = '{limit: 1000, haltStart: -1, wIdx: 5,  wVal: 2, coLoad: 0, hostPoke: 1, expCount: 1001, expPass: 1, expTo: 1};
    vecs[2] = '{limit: 10,   haltStart: 6,  wIdx: 2,  wVal: 3, coLoad: 0, hostPoke: 0, expCount: 11,   expPass: 0, expTo: 0};
    vecs[3] = '{limit: 0,    haltStart: -1, wIdx: -1, wVal: 0, coLoad: 0, hostPoke: 0, expCount: 1,    expPass: 0, expTo: 1};
    vecs[4] = '{limit: 9,    haltStart: 6,  wIdx: 9,  wVal: 2, coLoad: 0, hostPoke: 0, expCount: 10,   expPass: 1, expTo: 1};
    vecs[5] = '{limit: 20,   haltStart: 0,  wIdx: -1, wVal: 0, coLoad: 0, hostPoke: 0, expCount: 5,    expPass: 1, expTo: 0};

    reset = 1'b1;
    start = 1'b0;
    timeout_limit = '0;
    load_valid = 1'b0;
    load_addr = '0;
    load_data = '0;
    cpu_instruction = '0;
    cpu_write_en = 1'b0;
    cpu_write_addr = '0;
    cpu_write_val = '0;
    cpu_read_addr = '0;
    #1;
    check("reset_cpu_reset", cpu_reset, 1);
    check("reset_load_ready", load_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_timed_out", timed_out, 0);
    check("reset_cycle_count", cycle_count, 0);
    check("reset_mem_write_en", mem_write_en, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    preload(8'd135, 8'h00);
    preload(8'd200, 8'h11);
    preload(8'd201, 8'h22);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 1024; i++) begin
        opSeq[i] = (vecs[v].haltStart >= 0 && i >= vecs[v].haltStart) ? 4'hF : 4'($urandom_range(0, 14));
      end
      runOne($sformatf("vec%0d", v), vecs[v].limit, vecs[v].wIdx, 8'(vecs[v].wVal),
             vecs[v].coLoad, vecs[v].hostPoke, 1'b1, vecs[v].expCount, vecs[v].expPass, vecs[v].expTo);
    end

    // Randomised runs against the model.
    for (int r = 0; r < 8; r++) begin
      int limit;
      int wIdx;
      logic [7:0] wVal;
      limit = int'($urandom_range(0, 60));
      for (int i = 0; i < 1024; i++) begin
        opSeq[i] = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 14));
      end
      wIdx = int'($urandom_range(0, limit + 1)) - 1;
      wVal = ($urandom_range(0, 1) == 1) ? 8'd2 : 8'($urandom);
      runOne($sformatf("rnd%0d", r), limit, wIdx, wVal, 1'b0, 1'($urandom_range(0, 1)),
             1'b0, 0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a long run.
    for (int i = 0; i < 1024; i++) opSeq[i] = 4'($urandom_range(0, 14));
    start = 1'b1;
    timeout_limit = TIMER_BITS'(1000);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 50; i++) begin
      cpu_instruction = {opSeq[i], 8'h00};
      @(negedge clock);
    end
    check("midrun_in_run", cpu_reset, 0);
    reset = 1'b1;
    cpu_write_en = 1'b1;
    cpu_write_addr = 8'd201;
    cpu_write_val = 8'h99;
    #1;
    check("midrun_cpu_reset", cpu_reset, 1);
    check("midrun_busy", busy, 0);
    check("midrun_done", done, 0);
    check("midrun_load_ready", load_ready, 1);
    check("midrun_mem_write_en", mem_write_en, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("midrun_no_write", mem_write_en, 0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("after_reset_no_write", mem_write_en, 0);
    check("after_reset_cycle_count", cycle_count, 0);
    cpu_write_en = 1'b0;
    @(negedge clock);
    check("after_reset_ram_201", ram[201], shadow[201]);
    check("after_reset_ram_result", ram[RES_ADDR], shadow[RES_ADDR]);
    $display("run midrun_reset cpu_reset=%0b busy=%0b", cpu_reset, busy);

    // One run after the reset: RAM result from earlier runs must have survived.
    for (int i = 0; i < 1024; i++) opSeq[i] = (i >= 3) ? 4'hF : 4'h1;
    runOne("post_reset", 30, -1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
